// File: rtl/sample_bank.sv
`default_nettype none
// ============================================================================
// Module   : sample_bank
// Brief    : Captures a frame of packed samples into RAM and replays it
//            continuously. Defining SAMPLE_BANK_PASS_LIMIT_EN adds pass_limit,
//            done and the PB_DONE state.
// Revision : 1.0 - initial release
// ============================================================================
module sample_bank #(
    parameter int SAMPLE_WIDTH     = 3,
    parameter int SAMPLES_PER_WORD = 8,
    parameter int NUM_WORDS        = 8192,
    parameter int ADDR_WIDTH       = 13,
    parameter int FRAME_SAMPLES    = 50400
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    input  logic                    data_available,
    input  logic                    mode,
    input  logic                    sample_ready,
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
    input  logic [15:0]             pass_limit,
    output logic                    done,
`endif
    output logic                    ready,
    output logic                    sample_valid,
    output logic [SAMPLE_WIDTH-1:0] data_out,
    output logic                    frame_start,
    output logic                    frame_end,
    output logic [15:0]             pass_count
);

    localparam int c_WORD_W      = SAMPLE_WIDTH * SAMPLES_PER_WORD;
    localparam int c_FRAME_WORDS = FRAME_SAMPLES / SAMPLES_PER_WORD;
    localparam int c_CNT_W       = $clog2(FRAME_SAMPLES + 1);
    localparam int c_PACK_W      = $clog2(SAMPLES_PER_WORD + 1);
    localparam int c_WIDX_W      = $clog2(c_FRAME_WORDS + 1);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [c_CNT_W-1:0]    c_F_LAST    = c_CNT_W'(FRAME_SAMPLES - 1);
    localparam logic [c_CNT_W-1:0]    c_F_FULL    = c_CNT_W'(FRAME_SAMPLES);
    localparam logic [c_PACK_W-1:0]   c_PACK_LAST = c_PACK_W'(SAMPLES_PER_WORD - 1);
    localparam logic [c_PACK_W-1:0]   c_PACK_FULL = c_PACK_W'(SAMPLES_PER_WORD);
    localparam logic [c_PACK_W-1:0]   c_PACK_ONE  = c_PACK_W'(1);
    localparam logic [c_WIDX_W-1:0]   c_WIDX_LAST = c_WIDX_W'(c_FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_FULL     = 3'd1,
        ST_PB_PRIME = 3'd2,
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
        ST_PB_RUN   = 3'd3,
        ST_PB_DONE  = 3'd4
`else
        ST_PB_RUN   = 3'd3
`endif
    } state_t;

    state_t r_state, w_state_nxt;

    logic [c_WORD_W-1:0]   r_mem [NUM_WORDS];
    logic [c_WORD_W-1:0]   r_pack, r_pf, r_obuf;
    logic [c_PACK_W-1:0]   r_pack_cnt, r_ob_cnt;
    logic                  r_wr_pend, r_pf_valid, r_prime;
    logic [ADDR_WIDTH-1:0] r_wr_addr, r_start_addr, r_rd_addr;
    logic [c_CNT_W-1:0]    r_sample_count, r_samp_idx;
    logic [c_WIDX_W-1:0]   r_rd_word;
    logic [15:0]           r_pass_count, w_pass_nxt;
    logic                  w_accept, w_word_done, w_frame_full, w_valid, w_out_accept;
    logic                  w_last_sample, w_pf_take, w_rd_en, w_in_pb, w_enter_pb, w_leave_pb;

    function automatic logic [ADDR_WIDTH-1:0] f_wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == c_LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign w_in_pb       = (r_state == ST_PB_PRIME) || (r_state == ST_PB_RUN);
    assign w_valid       = (r_state == ST_PB_RUN);
    assign w_accept      = data_available && ((r_state == ST_FILL) || ((r_state == ST_FULL) && !mode));
    assign w_word_done   = w_accept && (r_pack_cnt == c_PACK_LAST);
    assign w_frame_full  = w_accept && (r_state == ST_FILL) && (r_sample_count == c_F_LAST);
    assign w_out_accept  = w_valid && sample_ready;
    assign w_last_sample = (r_samp_idx == c_F_LAST);
    // The prefetch word moves into the output buffer on the second prime cycle
    // and whenever the last sample of the current word is accepted.
    assign w_pf_take     = ((r_state == ST_PB_PRIME) && r_prime) ||
                           (w_out_accept && (r_ob_cnt == c_PACK_ONE));
    assign w_rd_en       = w_in_pb && (!r_pf_valid || w_pf_take);
    assign w_pass_nxt    = (w_out_accept && w_last_sample && (r_pass_count != 16'hFFFF)) ?
                           r_pass_count + 16'd1 : r_pass_count;
    assign w_enter_pb    = (w_state_nxt == ST_PB_PRIME) && (r_state != ST_PB_PRIME);
    assign w_leave_pb    = (w_state_nxt == ST_FILL) && (r_state != ST_FILL) && (r_state != ST_FULL);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_FILL;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:     if (w_frame_full) w_state_nxt = mode ? ST_PB_PRIME : ST_FULL;
            ST_FULL:     if (mode) w_state_nxt = ST_PB_PRIME;
            ST_PB_PRIME: begin
                if (!mode)        w_state_nxt = ST_FILL;
                else if (r_prime) w_state_nxt = ST_PB_RUN;
            end
            ST_PB_RUN: begin
                if (!mode) w_state_nxt = ST_FILL;
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
                else if ((pass_limit != 16'd0) && (w_pass_nxt >= pass_limit))
                    w_state_nxt = ST_PB_DONE;
            end
            ST_PB_DONE: begin
                if (!mode) w_state_nxt = ST_FILL;
`endif
            end
            default:     w_state_nxt = ST_FILL;
        endcase
    end

    // A completed word is written one cycle after packing; that write drains
    // even if playback was entered on the same edge, so the frame is whole.
    always_ff @(posedge clk) begin
        if (reset && r_wr_pend) r_mem[r_wr_addr] <= r_pack;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pack         <= '0;
            r_pack_cnt     <= '0;
            r_wr_pend      <= 1'b0;
            r_wr_addr      <= '0;
            r_start_addr   <= '0;
            r_sample_count <= '0;
            r_rd_addr      <= '0;
            r_rd_word      <= '0;
            r_pf           <= '0;
            r_pf_valid     <= 1'b0;
            r_obuf         <= '0;
            r_ob_cnt       <= '0;
            r_prime        <= 1'b0;
            r_samp_idx     <= '0;
            r_pass_count   <= '0;
        end else begin
            if (w_accept) begin
                r_pack     <= (r_pack << SAMPLE_WIDTH) | c_WORD_W'(data_in);
                r_pack_cnt <= w_word_done ? '0 : r_pack_cnt + c_PACK_ONE;
                if (r_sample_count != c_F_FULL)
                    r_sample_count <= r_sample_count + c_CNT_W'(1);
            end
            r_wr_pend <= w_word_done;
            if (r_wr_pend)
                r_wr_addr <= f_wrap_inc(r_wr_addr);
            // Advanced at pack time so it already accounts for the pending write.
            if (w_word_done && (r_state == ST_FULL))
                r_start_addr <= f_wrap_inc(r_start_addr);

            if (r_state == ST_PB_PRIME)
                r_prime <= 1'b1;
            if (w_rd_en) begin
                r_pf      <= r_mem[r_rd_addr];
                r_rd_addr <= (r_rd_word == c_WIDX_LAST) ? r_start_addr : f_wrap_inc(r_rd_addr);
                r_rd_word <= (r_rd_word == c_WIDX_LAST) ? '0 : r_rd_word + c_WIDX_W'(1);
            end
            if (w_rd_en)
                r_pf_valid <= 1'b1;
            else if (w_pf_take)
                r_pf_valid <= 1'b0;
            if (w_pf_take) begin
                r_obuf   <= r_pf;
                r_ob_cnt <= c_PACK_FULL;
            end else if (w_out_accept) begin
                r_obuf   <= r_obuf << SAMPLE_WIDTH;
                r_ob_cnt <= r_ob_cnt - c_PACK_ONE;
            end
            if (w_out_accept)
                r_samp_idx <= w_last_sample ? '0 : r_samp_idx + c_CNT_W'(1);
            r_pass_count <= w_pass_nxt;

            if (w_enter_pb) begin
                r_pack_cnt   <= '0;
                r_rd_addr    <= r_start_addr;
                r_rd_word    <= '0;
                r_pf_valid   <= 1'b0;
                r_prime      <= 1'b0;
                r_samp_idx   <= '0;
                r_pass_count <= '0;
            end
            if (w_leave_pb) begin
                r_pack_cnt     <= '0;
                r_wr_addr      <= '0;
                r_start_addr   <= '0;
                r_sample_count <= '0;
                r_pass_count   <= '0;
            end
        end
    end

    assign ready        = (r_state == ST_FULL) || w_in_pb;
    assign sample_valid = w_valid;
    assign data_out     = w_valid ? r_obuf[c_WORD_W-1 -: SAMPLE_WIDTH] : '0;
    assign frame_start  = w_valid && (r_samp_idx == '0);
    assign frame_end    = w_valid && w_last_sample;
    assign pass_count   = r_pass_count;
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
    assign done         = (r_state == ST_PB_DONE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_bank.sv
`default_nettype none
// Randomized bench for sample_bank with a queue-based model of the captured
// frame; scaled-down geometry keeps the run short while forcing RAM wrap.
module tb_sample_bank;
    localparam int c_SW  = 3;
    localparam int c_SPW = 4;
    localparam int c_NW  = 16;
    localparam int c_AW  = 4;
    localparam int c_F   = 48;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            data_available = 1'b0;
    logic            mode = 1'b0;
    logic            sample_ready = 1'b0;
    logic [c_SW-1:0] data_in = '0;
    logic            ready, sample_valid, frame_start, frame_end;
    logic [c_SW-1:0] data_out;
    logic [15:0]     pass_count;
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
    logic [15:0]     pass_limit = '0;
    logic            done;
`endif

    sample_bank #(
        .SAMPLE_WIDTH    (c_SW),
        .SAMPLES_PER_WORD(c_SPW),
        .NUM_WORDS       (c_NW),
        .ADDR_WIDTH      (c_AW),
        .FRAME_SAMPLES   (c_F)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_available(data_available),
        .mode          (mode),
        .sample_ready  (sample_ready),
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
        .pass_limit    (pass_limit),
        .done          (done),
`endif
        .ready         (ready),
        .sample_valid  (sample_valid),
        .data_out      (data_out),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .pass_count    (pass_count)
    );

    always #5 clk = ~clk;

    int              n_pass = 0;
    int              n_fail = 0;
    int              n_total = 0;
    logic [c_SW-1:0] cap[$];
    int              fill_cnt = 0;
    int              fbase = 0;
    int              pb_i = 0;
    int              lim = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
        check({tag, "_pass_count"}, 32'(pass_count), 32'd0);
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
        check({tag, "_done"}, 32'(done), 32'd0);
`endif
    endtask

    // Feed n accepted samples with random strobing; ready must track frame fill.
    task automatic capture(input int n);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 20 * n) begin
            data_available = ($urandom_range(2) != 0);
            data_in        = c_SW'($urandom);
            tick();
            cyc++;
            if (data_available) begin
                cap.push_back(data_in);
                got++;
                fill_cnt++;
            end
            check("ready_fill", 32'(ready), 32'(fill_cnt >= c_F));
        end
        data_available = 1'b0;
        if (got < n) check("capture_timeout", 32'(got), 32'(n));
    endtask

    // The frame replayed is the newest c_F samples among complete words.
    task automatic enter_playback(input bit entered);
        fbase = (cap.size() / c_SPW) * c_SPW - c_F;
        pb_i  = 0;
        if (!entered) begin
            mode = 1'b1;
            tick();
        end
        check("prime1_valid", 32'(sample_valid), 32'd0);
        check("prime1_ready", 32'(ready), 32'd1);
        tick();
        check("prime2_valid", 32'(sample_valid), 32'd0);
        check("prime2_ready", 32'(ready), 32'd1);
        tick();
    endtask

    task automatic play(input int ncyc, input bit rnd);
        bit exp_v;
        int k;
        int exp_pass;
        for (int c = 0; c < ncyc; c++) begin
            exp_v    = !(lim != 0 && pb_i >= lim * c_F);
            k        = pb_i % c_F;
            exp_pass = (pb_i / c_F > 65535) ? 65535 : pb_i / c_F;
            check("pb_valid", 32'(sample_valid), 32'(exp_v));
            check("pb_ready", 32'(ready), 32'(exp_v));
            if (exp_v) begin
                check("pb_data_out", 32'(data_out), 32'(cap[fbase + k]));
                check("pb_frame_start", 32'(frame_start), 32'(k == 0));
                check("pb_frame_end", 32'(frame_end), 32'(k == c_F - 1));
            end
            check("pb_pass_count", 32'(pass_count), 32'(exp_pass));
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
            check("pb_done", 32'(done), 32'(!exp_v));
`endif
            sample_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            tick();
            if (exp_v && sample_ready) pb_i++;
        end
    endtask

    initial begin
        // Reset with noise on the inputs.
        repeat (3) begin
            data_available = 1'($urandom_range(1));
            data_in        = c_SW'($urandom);
            tick();
        end
        data_available = 1'b0;
        check_idle_outputs("reset");
        reset = 1'b1;
        tick();

        // One full frame, then one extra word plus a partial word.
        capture(c_F);
        capture(c_SPW + 2);
        enter_playback(1'b0);
        play(6 * c_F, 1'b1);
        play(2 * c_F + 2, 1'b0);

        // Reset mid-playback, then capture with mode already high in FILL.
        reset = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset_pb");
        reset = 1'b1;
        mode  = 1'b0;
        tick();
        check("post_reset_ready", 32'(ready), 32'd0);
        cap.delete();
        fill_cnt = 0;
        mode = 1'b1;
        capture(c_F);
        enter_playback(1'b1);
        play(c_F + 4, 1'b0);

        // Back to capture; overrun the RAM so addresses wrap.
        mode         = 1'b0;
        sample_ready = 1'b0;
        tick();
        check("mode0_ready", 32'(ready), 32'd0);
        check("mode0_valid", 32'(sample_valid), 32'd0);
        cap.delete();
        fill_cnt = 0;
        capture(c_F + 6 * c_SPW);
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
        lim        = 3;
        pass_limit = 16'd3;
`endif
        enter_playback(1'b0);
        play(3 * c_F + 4, 1'b0);
        mode = 1'b0;
        tick();
        check("end_ready", 32'(ready), 32'd0);
        check("end_valid", 32'(sample_valid), 32'd0);
`ifdef SAMPLE_BANK_PASS_LIMIT_EN
        check("end_done", 32'(done), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
